// File: rtl/mips_pkg.sv
// Shared constants and types for the fetch stage.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // S_KILL: a request was outstanding when a redirect hit; its response must be swallowed.
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight and
// buffers the returned word for the IF/ID register, inserting NOPs when empty.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4_IF,
    output logic [31:0] Instr_IF,
    output logic        valid_IF,
    output logic [1:0]  state_dbg
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  req_pc4;
    logic         f_valid;
    logic [31:0]  f_instr;
    logic [31:0]  f_pc4;
    logic         accept;
    logic         consume;

    // Handshakes: a memory transfer happens only in a cycle with imem_req && imem_gnt, and
    // imem_req may be withdrawn without a grant; one cycle later at the earliest, imem_rvalid
    // returns the word. Toward IF/ID, the presented instruction is taken in any cycle with
    // valid_IF && !stall; while stall is high it is held unchanged.
    assign imem_req  = rst && (state == S_RUN) && (!f_valid || !stall) && !redirect_valid;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;
    assign consume   = f_valid && !stall;
    assign pc_next   = pc + 32'd4;

    assign pc4_IF    = f_pc4;
    assign Instr_IF  = f_valid ? f_instr : NOP_INSTR;
    assign valid_IF  = f_valid;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            req_pc4 <= 32'h0;
            state   <= S_RUN;
            f_valid <= 1'b0;
            f_instr <= NOP_INSTR;
            f_pc4   <= 32'h0;
        end else if (redirect_valid) begin
            // Redirect wins over stall and any response arriving this cycle.
            pc      <= redirect_pc;
            f_valid <= 1'b0;
            if (state == S_WAIT) begin
                state <= imem_rvalid ? S_RUN : S_KILL;
            end
        end else begin
            if (consume) begin
                f_valid <= 1'b0;
            end
            case (state)
                S_RUN: begin
                    if (accept) begin
                        pc      <= pc_next;
                        req_pc4 <= pc_next;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        f_instr <= imem_rdata;
                        f_pc4   <= req_pc4;
                        f_valid <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_KILL: begin
                    if (imem_rvalid) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a simple latency-programmable instruction memory.
module tb_instr_fetch;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc4_IF;
    logic [31:0] Instr_IF;
    logic        valid_IF;
    logic [1:0]  state_dbg;

    logic        rst2;
    logic        stall2;
    logic        redir2;
    logic [31:0] redir_pc2;
    logic        req2;
    logic [31:0] addr2;
    logic        gnt2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [31:0] pc4_2;
    logic [31:0] instr2;
    logic        valid2;
    logic [1:0]  state2;

    int          tests;
    int          failed;
    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic        mem_acc;
    logic [31:0] mem_acc_addr;

    instr_fetch dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc4_IF(pc4_IF), .Instr_IF(Instr_IF), .valid_IF(valid_IF), .state_dbg(state_dbg)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst2), .stall(stall2),
        .redirect_valid(redir2), .redirect_pc(redir_pc2),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .pc4_IF(pc4_2), .Instr_IF(instr2), .valid_IF(valid2), .state_dbg(state2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    // Word at address A is 32'hC000_0000 | A; rvalid arrives mem_lat cycles after accept.
    initial begin
        mem_cnt     = 0;
        mem_addr    = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        mem_acc      = imem_req && imem_gnt;
        mem_acc_addr = imem_addr;
        #1;
        if (!rst) mem_cnt = 0;
        else if (mem_acc) begin
            mem_cnt  = mem_lat;
            mem_addr = mem_acc_addr;
        end else if (mem_cnt != 0) mem_cnt = mem_cnt - 1;
        imem_rvalid = (mem_cnt == 1);
        imem_rdata  = imem_rvalid ? (32'hC000_0000 | mem_addr) : 32'hDEAD_BEEF;
    end

    // Response while the fetch unit is idle is a memory protocol error.
    always @(negedge clk) begin
        if (rst && imem_rvalid && state_dbg == S_RUN) begin
            failed++;
            $display("FAIL proto_rvalid_in_run: rvalid=1 state=%0d expected no rvalid in S_RUN", state_dbg);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b1;
        mem_lat        = 1;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b1; mem_lat = 1;
        next_cycle();
        #3;
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rst_req: got %0b expected 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin failed++; $display("FAIL rst_addr: got %h expected 00000000", imem_addr); end
        tests++; if (pc4_IF !== 32'h0) begin failed++; $display("FAIL rst_pc4: got %h expected 00000000", pc4_IF); end
        tests++; if (Instr_IF !== 32'h0) begin failed++; $display("FAIL rst_instr: got %h expected 00000000", Instr_IF); end
        tests++; if (valid_IF !== 1'b0) begin failed++; $display("FAIL rst_valid: got %0b expected 0", valid_IF); end
        tests++; if (state_dbg !== 2'd0) begin failed++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc4;
        do_reset();
        #3;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failed++; $display("FAIL t1_first_req: got req=%0b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            exp_pc4 = 32'(4 * (i + 1));
            next_cycle(); #3;
            tests++; if (valid_IF !== 1'b0 || imem_req !== 1'b0) begin failed++; $display("FAIL t1_wait_%0d: got valid=%0b req=%0b expected 0 0", i, valid_IF, imem_req); end
            next_cycle(); #3;
            tests++; if (valid_IF !== 1'b1 || pc4_IF !== exp_pc4) begin failed++; $display("FAIL t1_pc4_%0d: got valid=%0b pc4=%h expected 1 %h", i, valid_IF, pc4_IF, exp_pc4); end
            tests++; if (Instr_IF !== (32'hC000_0000 | (exp_pc4 - 32'd4))) begin failed++; $display("FAIL t1_instr_%0d: got %h expected %h", i, Instr_IF, 32'hC000_0000 | (exp_pc4 - 32'd4)); end
            tests++; if (imem_req !== 1'b1 || imem_addr !== exp_pc4) begin failed++; $display("FAIL t1_req_%0d: got req=%0b addr=%h expected 1 %h", i, imem_req, imem_addr, exp_pc4); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        next_cycle();
        next_cycle();
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #3;
            tests++; if (valid_IF !== 1'b1 || pc4_IF !== 32'h4 || Instr_IF !== 32'hC000_0000) begin failed++; $display("FAIL t2_hold_%0d: got valid=%0b pc4=%h instr=%h expected 1 00000004 c0000000", j, valid_IF, pc4_IF, Instr_IF); end
            tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL t2_noreq_%0d: got %0b expected 0", j, imem_req); end
            next_cycle();
        end
        stall = 1'b0;
        #3;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || valid_IF !== 1'b1) begin failed++; $display("FAIL t2_resume: got req=%0b addr=%h valid=%0b expected 1 00000004 1", imem_req, imem_addr, valid_IF); end
        next_cycle(); #3;
        tests++; if (valid_IF !== 1'b0) begin failed++; $display("FAIL t2_consumed: got %0b expected 0", valid_IF); end
        next_cycle(); #3;
        tests++; if (valid_IF !== 1'b1 || pc4_IF !== 32'h8 || Instr_IF !== 32'hC000_0004) begin failed++; $display("FAIL t2_next: got valid=%0b pc4=%h instr=%h expected 1 00000008 c0000004", valid_IF, pc4_IF, Instr_IF); end
    endtask

    task automatic test_no_grant();
        do_reset();
        imem_gnt = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #3;
            tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failed++; $display("FAIL t3_req_%0d: got req=%0b addr=%h expected 1 00000000", j, imem_req, imem_addr); end
            tests++; if (valid_IF !== 1'b0 || Instr_IF !== 32'h0) begin failed++; $display("FAIL t3_nop_%0d: got valid=%0b instr=%h expected 0 00000000", j, valid_IF, Instr_IF); end
            next_cycle();
        end
        imem_gnt = 1'b1;
        next_cycle();
        next_cycle(); #3;
        tests++; if (valid_IF !== 1'b1 || pc4_IF !== 32'h4) begin failed++; $display("FAIL t3_after: got valid=%0b pc4=%h expected 1 00000004", valid_IF, pc4_IF); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        mem_lat = 4;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #3;
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL t4_req_in_redirect: got %0b expected 0", imem_req); end
        next_cycle();
        redirect_valid = 1'b0;
        mem_lat        = 1;
        #3;
        tests++; if (state_dbg !== 2'd2 || imem_req !== 1'b0) begin failed++; $display("FAIL t4_kill: got state=%0d req=%0b expected 2 0", state_dbg, imem_req); end
        next_cycle();
        next_cycle(); #3;
        tests++; if (imem_req !== 1'b0 || valid_IF !== 1'b0) begin failed++; $display("FAIL t4_drop_cycle: got req=%0b valid=%0b expected 0 0", imem_req, valid_IF); end
        next_cycle(); #3;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid_IF !== 1'b0) begin failed++; $display("FAIL t4_newreq: got req=%0b addr=%h valid=%0b expected 1 00000100 0", imem_req, imem_addr, valid_IF); end
        next_cycle(); #3;
        tests++; if (valid_IF !== 1'b0) begin failed++; $display("FAIL t4_wait: got valid=%0b expected 0", valid_IF); end
        next_cycle(); #3;
        tests++; if (valid_IF !== 1'b1 || pc4_IF !== 32'h104 || Instr_IF !== 32'hC000_0100) begin failed++; $display("FAIL t4_target: got valid=%0b pc4=%h instr=%h expected 1 00000104 c0000100", valid_IF, pc4_IF, Instr_IF); end
    endtask

    task automatic test_redirect_buffer();
        do_reset();
        next_cycle();
        next_cycle();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #3;
        tests++; if (imem_req !== 1'b0 || valid_IF !== 1'b1) begin failed++; $display("FAIL t5_pre: got req=%0b valid=%0b expected 0 1", imem_req, valid_IF); end
        next_cycle();
        redirect_valid = 1'b0;
        #3;
        tests++; if (valid_IF !== 1'b0 || Instr_IF !== 32'h0) begin failed++; $display("FAIL t5_cleared: got valid=%0b instr=%h expected 0 00000000", valid_IF, Instr_IF); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failed++; $display("FAIL t5_req: got req=%0b addr=%h expected 1 00000200", imem_req, imem_addr); end
        stall = 1'b0;
        next_cycle();
        next_cycle(); #3;
        tests++; if (valid_IF !== 1'b1 || pc4_IF !== 32'h204 || Instr_IF !== 32'hC000_0200) begin failed++; $display("FAIL t5_target: got valid=%0b pc4=%h instr=%h expected 1 00000204 c0000200", valid_IF, pc4_IF, Instr_IF); end
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #3;
        tests++; if (imem_rvalid !== 1'b1 || state_dbg !== 2'd1) begin failed++; $display("FAIL t5_rvalid_wait: got rvalid=%0b state=%0d expected 1 1", imem_rvalid, state_dbg); end
        next_cycle();
        redirect_valid = 1'b0;
        #3;
        tests++; if (valid_IF !== 1'b0 || state_dbg !== 2'd0) begin failed++; $display("FAIL t5_dropped: got valid=%0b state=%0d expected 0 0", valid_IF, state_dbg); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failed++; $display("FAIL t5_req2: got req=%0b addr=%h expected 1 00000300", imem_req, imem_addr); end
        next_cycle();
        next_cycle(); #3;
        tests++; if (valid_IF !== 1'b1 || pc4_IF !== 32'h304) begin failed++; $display("FAIL t5_target2: got valid=%0b pc4=%h expected 1 00000304", valid_IF, pc4_IF); end
    endtask

    task automatic test_wrap_and_async_reset();
        next_cycle();
        rst2 = 1'b1;
        #3;
        tests++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin failed++; $display("FAIL t6_first: got req=%0b addr=%h expected 1 fffffffc", req2, addr2); end
        next_cycle();
        rvalid2 = 1'b1;
        rdata2  = 32'h1234_5678;
        #3;
        tests++; if (valid2 !== 1'b0) begin failed++; $display("FAIL t6_wait: got valid=%0b expected 0", valid2); end
        next_cycle();
        rvalid2 = 1'b0;
        #3;
        tests++; if (valid2 !== 1'b1 || pc4_2 !== 32'h0 || instr2 !== 32'h1234_5678) begin failed++; $display("FAIL t6_wrap_pc4: got valid=%0b pc4=%h instr=%h expected 1 00000000 12345678", valid2, pc4_2, instr2); end
        tests++; if (req2 !== 1'b1 || addr2 !== 32'h0) begin failed++; $display("FAIL t6_wrap_addr: got req=%0b addr=%h expected 1 00000000", req2, addr2); end

        do_reset();
        next_cycle();
        next_cycle();
        mem_lat = 3;
        #3;
        tests++; if (valid_IF !== 1'b1 || pc4_IF !== 32'h4 || imem_addr !== 32'h4) begin failed++; $display("FAIL t6_pre: got valid=%0b pc4=%h addr=%h expected 1 00000004 00000004", valid_IF, pc4_IF, imem_addr); end
        next_cycle();
        #1;
        tests++; if (state_dbg !== 2'd1 || pc4_IF !== 32'h4 || imem_addr !== 32'h8) begin failed++; $display("FAIL t6_inwait: got state=%0d pc4=%h addr=%h expected 1 00000004 00000008", state_dbg, pc4_IF, imem_addr); end
        rst = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || state_dbg !== 2'd0) begin failed++; $display("FAIL t6_async_ctl: got req=%0b addr=%h state=%0d expected 0 00000000 0", imem_req, imem_addr, state_dbg); end
        tests++; if (pc4_IF !== 32'h0 || Instr_IF !== 32'h0 || valid_IF !== 1'b0) begin failed++; $display("FAIL t6_async_out: got pc4=%h instr=%h valid=%0b expected 00000000 00000000 0", pc4_IF, Instr_IF, valid_IF); end
        next_cycle();
        next_cycle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests     = 0;
        failed    = 0;
        rst2      = 1'b0;
        stall2    = 1'b0;
        redir2    = 1'b0;
        redir_pc2 = 32'h0;
        gnt2      = 1'b1;
        rvalid2   = 1'b0;
        rdata2    = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_no_grant();
        test_redirect_wait();
        test_redirect_buffer();
        test_wrap_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
